// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its lane controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MAX_LOCK_DEF = 8;
    localparam int unsigned LOCK_CNT_W   = 8;

endpackage

// File: rtl/dmem_lane_ctl.sv
// Maps access size and low address bits onto byte enables, replicated write
// data and a misalignment flag. Pure combinational, shared with bus blocks.
module dmem_lane_ctl
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            default: begin
                // size 2'b11 is deliberately handled as a full word
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU data
// port (0) and the loader/DMA port (1), with a bounded burst lock for port 1.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for a request; picks the winner and latches it
// ST_ACCESS | mem_en cycle; writes and misaligned accesses ack here
// ST_RESP   | read data arrives from the RAM; winner's rdata loaded, ack
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [1:0]        size0_i,
    input  logic [1:0]        size1_i,
    input  logic [31:0]       addr0_i,
    input  logic [31:0]       addr1_i,
    input  logic [31:0]       wdata0_i,
    input  logic [31:0]       wdata1_i,
    input  logic              lock1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [31:0]       rdata0_o,
    output logic [31:0]       rdata1_o,
    output logic              cpu_stall_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(MAX_LOCK);

    state_e                 state_q;
    logic                   gnt_q;
    logic                   last_q;
    logic                   we_q;
    logic                   mis_q;
    logic                   lock_held_q;
    logic [LOCK_CNT_W-1:0]  lock_cnt_q;
    logic                   ack0_q, ack1_q;
    logic                   err0_q, err1_q;
    logic                   mem_en_q;
    logic [3:0]             mem_be_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [31:0]            mem_wdata_q;
    logic [31:0]            rdata0_q, rdata1_q;

    logic                   lock_hit;
    logic                   win_d;
    logic                   sel_we;
    logic [1:0]             sel_size;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_wdata;
    logic [LOCK_CNT_W-1:0]  lock_cnt_d;
    logic [3:0]             lane_be;
    logic [31:0]            lane_wdata;
    logic                   lane_mis;
    logic                   unused_addr_hi;

    // Lock keeps port 1 only if it asked for it on its last completion
    // and has not yet used up its burst allowance.
    always_comb begin
        lock_hit = last_q && lock_held_q && (lock_cnt_q < LOCK_LIMIT) && req1_i;
        if (lock_hit) begin
            win_d = 1'b1;
        end else if (req0_i && req1_i) begin
            win_d = ~last_q;
        end else begin
            win_d = req1_i;
        end
        sel_we     = win_d ? we1_i    : we0_i;
        sel_size   = win_d ? size1_i  : size0_i;
        sel_addr   = win_d ? addr1_i  : addr0_i;
        sel_wdata  = win_d ? wdata1_i : wdata0_i;
        lock_cnt_d = lock_hit ? lock_cnt_q + LOCK_CNT_W'(1) : '0;
    end

    assign unused_addr_hi = ^{sel_addr[31:ADDR_W+2]};

    dmem_lane_ctl u_lane_ctl (
        .size_i     (sel_size),
        .addr_lo_i  (sel_addr[1:0]),
        .wdata_i    (sel_wdata),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .misalign_o (lane_mis)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            lock_held_q <= 1'b0;
            lock_cnt_q  <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_be_q <= 4'b0000;
            case (state_q)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        gnt_q       <= win_d;
                        last_q      <= win_d;
                        lock_cnt_q  <= lock_cnt_d;
                        we_q        <= sel_we;
                        mis_q       <= lane_mis;
                        mem_addr_q  <= sel_addr[ADDR_W+1:2];
                        mem_wdata_q <= lane_wdata;
                        mem_en_q    <= ~lane_mis;
                        mem_be_q    <= (sel_we && !lane_mis) ? lane_be : 4'b0000;
                        // Writes and rejected accesses complete in the ACCESS cycle.
                        if (sel_we || lane_mis) begin
                            ack0_q <= ~win_d;
                            ack1_q <= win_d;
                            err0_q <= ~win_d & lane_mis;
                            err1_q <= win_d & lane_mis;
                        end
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (we_q || mis_q) begin
                        if (gnt_q) begin
                            lock_held_q <= lock1_i;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        ack0_q  <= ~gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (gnt_q) begin
                        rdata1_q    <= mem_rdata_i;
                        lock_held_q <= lock1_i;
                    end else begin
                        rdata0_q <= mem_rdata_i;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign err0_o      = err0_q;
    assign err1_o      = err1_q;
    assign mem_en_o    = mem_en_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_stall_o = req0_i & ~ack0_q;

    // RAM data is forwarded during the ack cycle so rdata is valid with ack;
    // the register keeps it afterwards.
    assign rdata0_o = (state_q == ST_RESP && !gnt_q) ? mem_rdata_i : rdata0_q;
    assign rdata1_o = (state_q == ST_RESP &&  gnt_q) ? mem_rdata_i : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock1 = 0;
    logic [1:0]  size0 = 0, size1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, err0, err1, cpu_stall, mem_en;
    logic [31:0] rdata0, rdata1, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] ram [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(10), .MAX_LOCK(3)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .size0_i(size0), .size1_i(size1), .addr0_i(addr0), .addr1_i(addr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1), .lock1_i(lock1),
        .ack0_o(ack0), .ack1_o(ack1), .err0_o(err0), .err1_o(err1),
        .rdata0_o(rdata0), .rdata1_o(rdata1), .cpu_stall_o(cpu_stall),
        .mem_en_o(mem_en), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_be == 4'b0000) begin
                mem_rdata <= ram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = rq; we0 = w; size0 = s; addr0 = a; wdata0 = d;
        end else begin
            req1 = rq; we1 = w; size1 = s; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        lock1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 32'({ack0, ack1, err0, err1, cpu_stall, mem_en, mem_be}), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
    endtask

    // Starts and ends at posedge+1; lat is the cycle index of the ack.
    task automatic access(input int p, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic er, output logic [31:0] rd,
                          output logic en_seen, output logic [3:0] be_seen,
                          output logic [9:0] ad_seen, output logic [31:0] wd_seen,
                          output int stall_n);
        logic done;
        lat = -1; er = 0; rd = 0; en_seen = 0; be_seen = 0; ad_seen = 0; wd_seen = 0;
        stall_n = 0; done = 0;
        drive(p, 1, w, s, a, d);
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (mem_en) begin
                en_seen = 1; be_seen = mem_be; ad_seen = mem_addr; wd_seen = mem_wdata;
            end
            if (cpu_stall) stall_n++;
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                done = 1;
                lat = k;
                er = (p == 1) ? err1 : err0;
                rd = (p == 1) ? rdata1 : rdata0;
            end
            @(posedge clk);
            #1;
        end
        drive(p, 0, 0, 2'b00, 0, 0);
        chk("ack_seen", 32'(done), 32'd1);
    endtask

    // Both ports issue word writes; order records grants, oldest in MSB.
    task automatic run_pair(input int n0, input int n1, input int d0,
                            output logic [15:0] order, output int overlap);
        int c0, c1, cyc;
        c0 = n0; c1 = n1; cyc = 0; order = 0; overlap = 0;
        for (int k = 0; k < 100 && (c0 > 0 || c1 > 0); k++) begin
            drive(0, (c0 > 0) && (cyc >= d0), 1, SZ_WORD, 32'h100 + 32'(4*(n0-c0)), 32'hA000 + 32'(c0));
            drive(1, (c1 > 0), 1, SZ_WORD, 32'h200 + 32'(4*(n1-c1)), 32'hB000 + 32'(c1));
            @(negedge clk);
            if (ack0 && ack1) overlap++;
            if (ack0) begin order = {order[14:0], 1'b0}; c0--; end
            if (ack1) begin order = {order[14:0], 1'b1}; c1--; end
            @(posedge clk);
            #1;
            cyc++;
        end
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        chk("pair_done", 32'((c0 == 0) && (c1 == 0)), 32'd1);
    endtask

    initial begin
        int lat, stn, ovl, spur;
        logic er, en;
        logic [31:0] rd, wd;
        logic [3:0] be;
        logic [9:0] ad;
        logic [15:0] ord;

        #2;
        apply_reset();

        access(0, 1, SZ_WORD, 32'h10, 32'hDEADBEEF, lat, er, rd, en, be, ad, wd, stn);
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_be", 32'(be), 32'hF);
        chk("wr_addr", 32'(ad), 32'd4);
        chk("wr_err", 32'(er), 32'd0);
        chk("wr_stall", 32'(stn), 32'd1);

        access(0, 0, SZ_WORD, 32'h10, 32'h0, lat, er, rd, en, be, ad, wd, stn);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_stall", 32'(stn), 32'd2);
        chk("rd_be", 32'(be), 32'd0);
        chk("rdata0_hold", rdata0, 32'hDEADBEEF);

        access(0, 1, SZ_BYTE, 32'h13, 32'h123456A5, lat, er, rd, en, be, ad, wd, stn);
        chk("byte_be", 32'(be), 32'h8);
        chk("byte_wd", wd, 32'hA5A5A5A5);

        access(0, 1, SZ_HALF, 32'h12, 32'hABCD1234, lat, er, rd, en, be, ad, wd, stn);
        chk("half_be", 32'(be), 32'hC);
        chk("half_wd", wd, 32'h12341234);

        access(1, 0, SZ_WORD, 32'h10, 32'h0, lat, er, rd, en, be, ad, wd, stn);
        chk("rd1_lat", 32'(lat), 32'd2);
        chk("rd1_data", rd, 32'h1234BEEF);
        chk("rdata0_kept", rdata0, 32'hDEADBEEF);

        access(1, 0, SZ_WORD, 32'h6, 32'h0, lat, er, rd, en, be, ad, wd, stn);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_en", 32'(en), 32'd0);
        chk("mis_rdata1", rdata1, 32'h1234BEEF);

        access(0, 1, SZ_HALF, 32'h11, 32'hFFFF, lat, er, rd, en, be, ad, wd, stn);
        chk("mish_err", 32'(er), 32'd1);
        chk("mish_en", 32'(en), 32'd0);

        apply_reset();
        run_pair(2, 2, 0, ord, ovl);
        chk("alt_order", 32'(ord), 32'h5);
        chk("alt_overlap", 32'(ovl), 32'd0);

        lock1 = 1'b1;
        run_pair(1, 5, 1, ord, ovl);
        chk("lock_order", 32'(ord), 32'h3D);
        chk("lock_overlap", 32'(ovl), 32'd0);
        chk("lock_cnt_clr", 32'(dut.lock_cnt_q), 32'd0);
        lock1 = 1'b0;

        drive(0, 1, 0, SZ_WORD, 32'h10, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("resp_ack", 32'(ack0), 32'd1);
        rst_n = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0);
        #1;
        chk("mrst_ctl", 32'({ack0, ack1, err0, err1, cpu_stall, mem_en, mem_be}), 32'd0);
        chk("mrst_rdata0", rdata0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        spur = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) spur++;
        end
        chk("mrst_no_ack", 32'(spur), 32'd0);
        @(posedge clk);
        #1;
        access(0, 0, SZ_WORD, 32'h10, 32'h0, lat, er, rd, en, be, ad, wd, stn);
        chk("post_lat", 32'(lat), 32'd2);
        chk("post_data", rd, 32'h1234BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
